// File: rtl/seq_pattern_detector_if.sv
// Bundles the serial stream, control and result signals of seq_pattern_detector.
// The stimulus side takes the master modport and the detector takes the slave modport.
interface seq_pattern_detector_if #(
    parameter int unsigned PAT_W = 3,
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             in;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic             clear;
    logic             match;
    logic [CNT_W-1:0] count;
    logic             sat;

    modport master (
        output en, in, pattern, overlap, clear,
        input  match, count, sat
    );

    modport slave (
        input  en, in, pattern, overlap, clear,
        output match, count, sat
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// Serial detector for a run-time-programmable PAT_W-bit pattern, with optional overlap,
// an enable qualifier and a saturating match counter. All outputs are registered.
module seq_pattern_detector #(
    parameter int unsigned PAT_W = 3,
    parameter int unsigned CNT_W = 8
) (
    input logic                  clk,
    input logic                  reset,
    seq_pattern_detector_if.slave det_if
);
    localparam int unsigned FillW = $clog2(PAT_W + 1);
    localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);

    logic [PAT_W-1:0] hist_q, hist_d, hist_shift;
    logic [FillW-1:0] fill_q, fill_d, fill_inc;
    logic [CNT_W-1:0] count_q, count_d;
    logic             match_q, match_d;
    logic             sat_q, sat_d;
    logic             hit;

    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], det_if.in};
        fill_inc   = (fill_q == FillFull) ? fill_q : fill_q + FillW'(1);
        hit        = (fill_inc == FillFull) && (hist_shift == det_if.pattern);

        hist_d  = hist_q;
        fill_d  = fill_q;
        count_d = count_q;
        sat_d   = sat_q;
        match_d = 1'b0;

        if (det_if.clear) begin
            hist_d  = '0;
            fill_d  = '0;
            count_d = '0;
            sat_d   = 1'b0;
        end else if (det_if.en) begin
            hist_d  = hist_shift;
            // A non-overlapping hit makes the next match wait for PAT_W fresh bits.
            fill_d  = (hit && !det_if.overlap) ? '0 : fill_inc;
            match_d = hit;
            if (hit && (count_q != '1)) begin
                count_d = count_q + CNT_W'(1);
                if (count_d == '1) begin
                    sat_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            match_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            match_q <= match_d;
            sat_q   <= sat_d;
        end
    end

    assign det_if.match = match_q;
    assign det_if.count = count_q;
    assign det_if.sat   = sat_q;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector: directed scenarios followed by random
// stimulus, all compared against a queue-based reference model of the detection rules.
module tb_seq_pattern_detector;
    localparam int unsigned PAT_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CntMax = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    seq_pattern_detector_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) det_if ();

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .det_if (det_if)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: bits seen since the last reset, clear or non-overlapping hit.
    bit          fresh[$];
    bit          exp_match;
    int unsigned exp_count;
    bit          exp_sat;
    logic [PAT_W-1:0] pat;
    logic             ovl;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        fresh.delete();
        exp_match = 1'b0;
        exp_count = 0;
        exp_sat   = 1'b0;
    endfunction

    function automatic void model_edge(input logic e, input logic b, input logic c);
        int unsigned v;
        if (c) begin
            model_reset();
            return;
        end
        exp_match = 1'b0;
        if (!e) return;
        fresh.push_back(b);
        if (fresh.size() > PAT_W) void'(fresh.pop_front());
        if (fresh.size() == PAT_W) begin
            v = 0;
            foreach (fresh[i]) v = (v << 1) | int'(fresh[i]);
            if (v == int'(pat)) begin
                exp_match = 1'b1;
                if (exp_count < CntMax) exp_count++;
                exp_sat = (exp_count == CntMax);
                if (!ovl) fresh.delete();
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, "_match"}, 32'(det_if.match), 32'(exp_match));
        check_eq({tag, "_count"}, 32'(det_if.count), exp_count);
        check_eq({tag, "_sat"}, 32'(det_if.sat), 32'(exp_sat));
    endtask

    task automatic step(input logic e, input logic b, input logic c);
        @(negedge clk);
        det_if.en      = e;
        det_if.in      = b;
        det_if.clear   = c;
        det_if.pattern = pat;
        det_if.overlap = ovl;
        @(posedge clk);
        model_edge(e, b, c);
        #1;
        check_outputs("step");
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear without a clock.
    task automatic pulse_reset();
        det_if.en = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("arst_match", 32'(det_if.match), 32'd0);
        check_eq("arst_count", 32'(det_if.count), 32'd0);
        check_eq("arst_sat", 32'(det_if.sat), 32'd0);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic feed(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0);
    endtask

    initial begin
        det_if.en = 1'b0;
        det_if.in = 1'b0;
        det_if.clear = 1'b0;
        det_if.pattern = '0;
        det_if.overlap = 1'b0;
        pat = 3'b101;
        ovl = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_match", 32'(det_if.match), 32'd0);
        check_eq("rst_count", 32'(det_if.count), 32'd0);
        check_eq("rst_sat", 32'(det_if.sat), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Overlapping 10101: two matches.
        feed(32'b10101, 5);
        check_eq("ovl_count", 32'(det_if.count), 32'd2);
        pulse_reset();

        // Non-overlapping 10101: one match.
        ovl = 1'b0;
        feed(32'b10101, 5);
        check_eq("novl_count", 32'(det_if.count), 32'd1);
        pulse_reset();

        // Reset mid-stream discards the partial 10.
        ovl = 1'b1;
        feed(32'b10, 2);
        pulse_reset();
        feed(32'b1, 1);
        check_eq("midrst_nomatch", 32'(det_if.match), 32'd0);
        feed(32'b01, 2);
        check_eq("midrst_match", 32'(det_if.match), 32'd1);
        pulse_reset();

        // Enable gaps with X on the input while disabled.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'bx, 1'b0);
        check_eq("gap_match0", 32'(det_if.match), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_eq("gap_match", 32'(det_if.match), 32'd1);
        check_eq("gap_count", 32'(det_if.count), 32'd1);
        pulse_reset();

        // Saturation: 1 followed by 01 x 16 gives 16 overlapping matches.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) feed(32'b01, 2);
        check_eq("sat_match", 32'(det_if.match), 32'd1);
        check_eq("sat_count", 32'(det_if.count), CntMax);
        check_eq("sat_flag", 32'(det_if.sat), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        check_eq("clr_count", 32'(det_if.count), 32'd0);
        check_eq("clr_sat", 32'(det_if.sat), 32'd0);

        // Clear on the edge that would complete 101.
        feed(32'b10, 2);
        step(1'b1, 1'b1, 1'b1);
        check_eq("clrhit_match", 32'(det_if.match), 32'd0);
        feed(32'b01, 2);
        check_eq("clrhit_after", 32'(det_if.match), 32'd0);
        check_eq("clrhit_count", 32'(det_if.count), 32'd0);

        // Random traffic with occasional pattern/overlap changes, clears and resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) pat = PAT_W'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) ovl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) step(1'b0, 1'bx, 1'b0);
                else step(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
